instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder.sv | 143 ++++++++++++++
 tb/tb_instr_encoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Interface bundling instr_encoder's control, command and imem-write signals.
// The master side drives commands and grants; the slave side is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_kind;
  logic [3:0]        cmd_cond;
  logic [3:0]        cmd_rd;
  logic [3:0]        cmd_rn;
  logic              cmd_i;
  logic              cmd_s;
  logic [11:0]       cmd_op2;
  logic [23:0]       cmd_offset;
  logic              imem_req;
  logic              imem_gnt;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   wr_count;
  logic              err;
  logic              idle;

  modport master (
    output start, start_addr, cmd_valid, cmd_kind, cmd_cond, cmd_rd, cmd_rn,
           cmd_i, cmd_s, cmd_op2, cmd_offset, imem_gnt,
    input  cmd_ready, imem_req, imem_addr, imem_wdata, wr_count, err, idle
  );

  modport slave (
    input  start, start_addr, cmd_valid, cmd_kind, cmd_cond, cmd_rd, cmd_rn,
           cmd_i, cmd_s, cmd_op2, cmd_offset, imem_gnt,
    output cmd_ready, imem_req, imem_addr, imem_wdata, wr_count, err, idle
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes ARM-style commands into 32-bit words, queues them and writes them to imem.
// Optional macro ENC_ERR_STICKY_EN: err stays high after an illegal command until rst/start.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] SAT_CNT  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [3:0] {
    K_MOV = 4'd0,  K_MVN = 4'd1,  K_ADD = 4'd2,  K_ADC = 4'd3,
    K_SUB = 4'd4,  K_SBC = 4'd5,  K_AND = 4'd6,  K_ORR = 4'd7,
    K_EOR = 4'd8,  K_CMP = 4'd9,  K_TST = 4'd10, K_LDR = 4'd11,
    K_STR = 4'd12, K_B   = 4'd13
  } kind_e;

  typedef enum logic [1:0] {C_DP, C_MEM, C_BR, C_ILL} class_e;

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_err;

  class_e      w_class;
  logic [3:0]  w_opc;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic        w_s;
  logic [31:0] w_word;
  logic        w_empty;
  logic        w_full;
  logic        w_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_req;

  always_comb begin
    w_class = C_DP;
    w_opc   = '0;
    w_rn    = bus.cmd_rn;
    w_rd    = bus.cmd_rd;
    w_s     = bus.cmd_s;
    case (kind_e'(bus.cmd_kind))
      K_MOV: begin w_opc = 4'b1101; w_rn = '0; end
      K_MVN: begin w_opc = 4'b1111; w_rn = '0; end
      K_ADD: w_opc = 4'b0100;
      K_ADC: w_opc = 4'b0101;
      K_SUB: w_opc = 4'b0010;
      K_SBC: w_opc = 4'b0110;
      K_AND: w_opc = 4'b0000;
      K_ORR: w_opc = 4'b1100;
      K_EOR: w_opc = 4'b0001;
      K_CMP: begin w_opc = 4'b1010; w_s = 1'b1; w_rd = '0; end
      K_TST: begin w_opc = 4'b1000; w_s = 1'b1; w_rd = '0; end
      K_LDR: w_class = C_MEM;
      K_STR: w_class = C_MEM;
      K_B:   w_class = C_BR;
      default: w_class = C_ILL;
    endcase
  end

  always_comb begin
    w_word = '0;
    case (w_class)
      C_DP:  w_word = {bus.cmd_cond, 2'b00, bus.cmd_i, w_opc, w_s, w_rn, w_rd, bus.cmd_op2};
      C_MEM: w_word = {bus.cmd_cond, 2'b01, 1'b0, 4'b0100, (bus.cmd_kind == K_LDR),
                       bus.cmd_rn, bus.cmd_rd, bus.cmd_op2};
      C_BR:  w_word = {bus.cmd_cond, 3'b101, 1'b0, bus.cmd_offset};
      default: w_word = '0;
    endcase
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_ready  = !rst && !bus.start && !w_full;
  assign w_accept = bus.cmd_valid && w_ready;
  assign w_push   = w_accept && (w_class != C_ILL);
  // Request is masked during reset so a queued word is never written in the reset cycle.
  assign w_req    = !rst && !w_empty;
  assign w_pop    = w_req && bus.imem_gnt;

  assign bus.cmd_ready  = w_ready;
  assign bus.imem_req   = w_req;
  assign bus.imem_wdata = w_req ? r_mem[r_rd_ptr] : '0;
  assign bus.imem_addr  = r_addr;
  assign bus.wr_count   = r_wr_count;
  assign bus.err        = r_err;
  assign bus.idle       = w_empty && !w_req;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else if (bus.start) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= bus.start_addr;
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
        if (r_wr_count != SAT_CNT) begin
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
`ifdef ENC_ERR_STICKY_EN
      r_err <= r_err || (w_accept && (w_class == C_ILL));
`else
      r_err <= w_accept && (w_class == C_ILL);
`endif
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed encodings.
module tb_instr_encoder;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [9:0]  log_addr [$];
  logic [31:0] log_data [$];

  instr_encoder_if #(.ADDR_W(10)) bus ();

  instr_encoder #(.ADDR_W(10), .DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] kind, input logic [3:0] cond, input logic i,
                         input logic s, input logic [3:0] rd, input logic [3:0] rn,
                         input logic [11:0] op2, input logic [23:0] off);
    bus.cmd_kind   = kind;
    bus.cmd_cond   = cond;
    bus.cmd_i      = i;
    bus.cmd_s      = s;
    bus.cmd_rd     = rd;
    bus.cmd_rn     = rn;
    bus.cmd_op2    = op2;
    bus.cmd_offset = off;
  endtask

  // MOV rd=k, op2=k, cond E -> 0xE1A0_0000 | k<<12 | k
  task automatic set_mov(input int unsigned k);
    set_cmd(4'd0, 4'hE, 1'b0, 1'b0, 4'(k), 4'hF, 12'(k), 24'h0);
  endtask

  function automatic logic [31:0] mov_word(input int unsigned k);
    return 32'hE1A0_0000 | (k << 12) | k;
  endfunction

  task automatic issue(input string tag, input logic [31:0] exp_word, input logic [9:0] exp_addr);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, "_req"}, bus.imem_req, 1);
    check({tag, "_wdata"}, bus.imem_wdata, exp_word);
    check({tag, "_addr"}, bus.imem_addr, exp_addr);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (bus.idle !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, bus.idle, 1);
  endtask

  task automatic do_start(input logic [9:0] a);
    bus.start      = 1'b1;
    bus.start_addr = a;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.cmd_valid  = 1'b0;
    bus.imem_gnt   = 1'b0;
    set_cmd(4'd0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0);
    tick();
    tick();
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wrcount", bus.wr_count, 0);
    check("rst_err", bus.err, 0);
    check("rst_idle", bus.idle, 1);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.cmd_ready, 1);

    // Single encodings with grant always high
    bus.imem_gnt = 1'b1;
    set_cmd(4'd2, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0);
    issue("add", 32'hE082_1003, 10'd0);
    check("add_wrcount", bus.wr_count, 1);
    check("add_addr_next", bus.imem_addr, 1);
    set_cmd(4'd9, 4'hE, 1'b1, 1'b0, 4'd7, 4'd3, 12'h005, 24'h0);
    issue("cmp", 32'hE353_0005, 10'd1);
    set_cmd(4'd11, 4'hE, 1'b1, 1'b0, 4'd4, 4'd0, 12'h008, 24'h0);
    issue("ldr", 32'hE490_4008, 10'd2);
    set_cmd(4'd12, 4'hE, 1'b0, 1'b1, 4'd4, 4'd0, 12'h008, 24'h0);
    issue("str", 32'hE480_4008, 10'd3);
    set_cmd(4'd13, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'hFF_FFFE);
    issue("b", 32'hEAFF_FFFE, 10'd4);
    set_cmd(4'd1, 4'h0, 1'b1, 1'b1, 4'd5, 4'd9, 12'h0FF, 24'h0);
    issue("mvn", 32'h03F0_50FF, 10'd5);
    set_cmd(4'd10, 4'h1, 1'b0, 1'b0, 4'd6, 4'd8, 12'h123, 24'h0);
    issue("tst", 32'h1118_0123, 10'd6);
    check("single_wrcount", bus.wr_count, 7);

    // Backpressure: fill FIFO, fifth command waits until after the first pop
    bus.imem_gnt = 1'b0;
    do_start(10'd0);
    check("start_addr0", bus.imem_addr, 0);
    check("start_wrcount", bus.wr_count, 0);
    log_addr.delete();
    log_data.delete();
    for (int unsigned k = 0; k < 5; k++) begin
      set_mov(k);
      bus.cmd_valid = 1'b1;
      #1;
      check($sformatf("fill_ready%0d", k), bus.cmd_ready, (k < 4) ? 1 : 0);
      if (k < 4) tick();
    end
    check("full_wdata", bus.imem_wdata, mov_word(0));
    check("full_addr", bus.imem_addr, 0);
    bus.imem_gnt = 1'b1;
    #1;
    check("full_pop_ready", bus.cmd_ready, 0);
    tick();
    check("after_pop_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    wait_idle("fill");
    check("fill_nwrites", log_addr.size(), 5);
    for (int unsigned k = 0; k < 5 && k < log_addr.size(); k++) begin
      check($sformatf("fill_addr%0d", k), log_addr[k], k);
      check($sformatf("fill_data%0d", k), log_data[k], mov_word(k));
    end
    check("fill_wrcount", bus.wr_count, 5);

    // Address wrap from 0x3FE with back-to-back commands
    do_start(10'h3FE);
    log_addr.delete();
    log_data.delete();
    for (int unsigned k = 0; k < 3; k++) begin
      set_mov(k + 8);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_idle("wrap");
    check("wrap_nwrites", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("wrap_a0", log_addr[0], 10'h3FE);
      check("wrap_a1", log_addr[1], 10'h3FF);
      check("wrap_a2", log_addr[2], 10'h000);
      check("wrap_d2", log_data[2], mov_word(10));
    end
    check("wrap_wrcount", bus.wr_count, 3);

    // Illegal command
    log_addr.delete();
    log_data.delete();
    set_cmd(4'd15, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 12'h0, 24'h0);
    bus.cmd_valid = 1'b1;
    #1;
    check("ill_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("ill_err", bus.err, 1);
    check("ill_req", bus.imem_req, 0);
    check("ill_idle", bus.idle, 1);
    tick();
`ifdef ENC_ERR_STICKY_EN
    check("ill_err_after", bus.err, 1);
`else
    check("ill_err_after", bus.err, 0);
`endif
    tick();
    check("ill_nwrites", log_addr.size(), 0);
    check("ill_wrcount", bus.wr_count, 3);

    // Start discards queued words
    bus.imem_gnt = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      set_mov(k);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("q2_req", bus.imem_req, 1);
    do_start(10'h100);
    check("st_idle", bus.idle, 1);
    check("st_req", bus.imem_req, 0);
    check("st_err", bus.err, 0);
    check("st_addr", bus.imem_addr, 10'h100);
    bus.imem_gnt = 1'b1;
    tick();
    tick();
    check("st_nwrites", log_addr.size(), 0);

    // Reset while a write is pending
    bus.imem_gnt = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      set_mov(k);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.imem_gnt  = 1'b1;
    rst = 1'b1;
    #1;
    check("rstw_req", bus.imem_req, 0);
    check("rstw_ready", bus.cmd_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstw_nwrites", log_addr.size(), 0);
    check("rstw_idle", bus.idle, 1);
    check("rstw_addr", bus.imem_addr, 0);
    check("rstw_wrcount", bus.wr_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
